// File: rtl/i2c_game_pkg.sv
// Shared constants, event classes and payload encoders for the game-event
// I2C scheduler. Payloads are packed as {P1 value[1:0], P2 value[1:0]}.
package i2c_game_pkg;

  localparam logic [6:0] P1_ADDR        = 7'h55;
  localparam logic [6:0] P2_ADDR        = 7'h2A;
  localparam logic [7:0] REG0_ADDR      = 8'h00;  // round standing
  localparam logic [7:0] REG1_ADDR      = 8'h01;  // match result
  localparam logic [7:0] REG2_ADDR      = 8'h02;  // ladder
  localparam logic [1:0] MODE_REG_WRITE = 2'b10;
  localparam logic [1:0] BURST_1BYTE    = 2'b00;
  localparam int         NUM_EVT        = 5;

  // Enum value doubles as the index of the class's pending latch.
  typedef enum logic [2:0] {
    EVT_RESTART = 3'd0,
    EVT_FINAL   = 3'd1,
    EVT_SHOW    = 3'd2,
    EVT_LAD_P1  = 3'd3,
    EVT_LAD_P2  = 3'd4
  } evt_class_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } sched_state_t;

  // Round standing -> {P1, P2} display values.
  function automatic logic [3:0] enc_win(input logic [1:0] win);
    case (win)
      2'b01:   enc_win = {2'd1, 2'd2};
      2'b10:   enc_win = {2'd2, 2'd1};
      default: enc_win = 4'h0;
    endcase
  endfunction

  // Match result -> {P1, P2} display values.
  function automatic logic [3:0] enc_result(input logic [1:0] res);
    case (res)
      2'b00:   enc_result = {2'd1, 2'd1};
      2'b01:   enc_result = {2'd2, 2'd3};
      2'b10:   enc_result = {2'd3, 2'd2};
      default: enc_result = 4'h0;
    endcase
  endfunction

  // Ladder tick -> value in the low bits; a down tick dominates an up tick.
  function automatic logic [3:0] enc_ladder(input logic up, input logic down);
    if (down) begin
      enc_ladder = 4'd1;
    end else if (up) begin
      enc_ladder = 4'd2;
    end else begin
      enc_ladder = 4'd0;
    end
  endfunction

endpackage

// File: rtl/i2c_evt_latch.sv
// One pending event: flag plus newest payload. Kill beats set, set beats
// the grant clear, so a capture coinciding with its own grant is kept.
module i2c_evt_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set,
  input  logic       i_clr,
  input  logic       i_kill,
  input  logic [3:0] i_payload,
  output logic       o_pending,
  output logic [3:0] o_payload,
  output logic       o_overrun
);

  logic       r_pending;
  logic [3:0] r_payload;

  // Pending flag and payload capture with kill > set > clear precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_payload <= 4'h0;
    end else if (i_kill) begin
      r_pending <= 1'b0;
    end else if (i_set) begin
      r_pending <= 1'b1;
      r_payload <= i_payload;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= r_pending;
    end
  end

  assign o_pending = r_pending;
  assign o_payload = r_payload;
  assign o_overrun = i_set & r_pending & ~i_kill;

endmodule

// File: rtl/i2c_event_scheduler.sv
// Game event -> I2C REG_WRITE scheduler. Captures event pulses, arbitrates
// restart > final > show > ladder_p1 > ladder_p2 and drives I2C_Master one
// single-byte write at a time. Optional macro I2C_SCHED_GAP_EN inserts
// GAP_CYCLES idle clocks after every m_done.
module i2c_event_scheduler
  import i2c_game_pkg::*;
`ifdef I2C_SCHED_GAP_EN
  #(parameter int unsigned GAP_CYCLES = 1000)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        game_final,
  input  logic [1:0]  game_result,
  input  logic        show,
  input  logic [1:0]  game_win,
  input  logic        up_p1,
  input  logic        down_p1,
  input  logic        up_p2,
  input  logic        down_p2,
  input  logic        m_ready,
  input  logic        m_done,
  output logic        m_start,
  output logic [1:0]  m_mode,
  output logic [1:0]  m_burst_len,
  output logic [6:0]  m_slave_addr,
  output logic [7:0]  m_reg_addr,
  output logic [31:0] m_tx_data,
  output logic        busy,
  output logic        overrun
);

  sched_state_t r_state, w_nxt_state, w_after_state;
  evt_class_t   r_cls, w_nxt_cls, w_grant;
  logic [1:0]   r_step, w_nxt_step, w_after_step;
  logic [3:0]   r_snap, w_sel_pay, w_cur_pay;
  logic [6:0]   r_slave, w_slave;
  logic [7:0]   r_reg, w_reg;
  logic [31:0]  r_data;
  logic [1:0]   w_val;
  logic         r_overrun, w_last, w_seq_end;
  logic [NUM_EVT-1:0] w_set, w_clr, w_kill, w_pend, w_ovr;
  logic [3:0]   w_in_pay [NUM_EVT];
  logic [3:0]   w_pay    [NUM_EVT];

  assign w_set  = {down_p2 | up_p2, down_p1 | up_p1, show, game_final, restart};
  // Restart wipes every other class, including captures in the same clock.
  assign w_kill = {restart, restart, restart, restart, 1'b0};
  assign w_clr  = ((r_state == ST_LOAD) && (r_step == 2'd0)) ? (5'b00001 << r_cls) : 5'b00000;

  assign w_in_pay[0] = 4'h0;
  assign w_in_pay[1] = enc_result(game_result);
  assign w_in_pay[2] = enc_win(game_win);
  assign w_in_pay[3] = enc_ladder(up_p1, down_p1);
  assign w_in_pay[4] = enc_ladder(up_p2, down_p2);

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_latch
    i2c_evt_latch u_latch (
      .clk       (clk),
      .rst       (rst),
      .i_set     (w_set[g]),
      .i_clr     (w_clr[g]),
      .i_kill    (w_kill[g]),
      .i_payload (w_in_pay[g]),
      .o_pending (w_pend[g]),
      .o_payload (w_pay[g]),
      .o_overrun (w_ovr[g])
    );
  end

  // Fixed-priority pick among pending classes and payload of the held class.
  always_comb begin
    w_grant   = EVT_RESTART;
    w_sel_pay = 4'h0;
    if (w_pend[0])      w_grant = EVT_RESTART;
    else if (w_pend[1]) w_grant = EVT_FINAL;
    else if (w_pend[2]) w_grant = EVT_SHOW;
    else if (w_pend[3]) w_grant = EVT_LAD_P1;
    else                w_grant = EVT_LAD_P2;
    case (r_cls)
      EVT_RESTART: w_sel_pay = w_pay[0];
      EVT_FINAL:   w_sel_pay = w_pay[1];
      EVT_SHOW:    w_sel_pay = w_pay[2];
      EVT_LAD_P1:  w_sel_pay = w_pay[3];
      EVT_LAD_P2:  w_sel_pay = w_pay[4];
      default:     w_sel_pay = 4'h0;
    endcase
  end

  // Step 0 takes the live latch payload (the grant snapshot); later steps reuse it.
  assign w_cur_pay = (r_step == 2'd0) ? w_sel_pay : r_snap;

  // Per-class write table: slave, register, value and last-step flag.
  always_comb begin
    w_slave = P1_ADDR;
    w_reg   = REG0_ADDR;
    w_val   = 2'b00;
    w_last  = 1'b1;
    case (r_cls)
      EVT_RESTART: begin
        w_slave = r_step[1] ? P2_ADDR : P1_ADDR;
        w_reg   = r_step[0] ? REG1_ADDR : REG0_ADDR;
        w_last  = (r_step == 2'd3);
      end
      EVT_FINAL, EVT_SHOW: begin
        w_slave = r_step[0] ? P2_ADDR : P1_ADDR;
        w_reg   = (r_cls == EVT_FINAL) ? REG1_ADDR : REG0_ADDR;
        w_val   = r_step[0] ? w_cur_pay[1:0] : w_cur_pay[3:2];
        w_last  = r_step[0];
      end
      EVT_LAD_P1: begin
        w_reg = REG2_ADDR;
        w_val = w_cur_pay[1:0];
      end
      EVT_LAD_P2: begin
        w_slave = P2_ADDR;
        w_reg   = REG2_ADDR;
        w_val   = w_cur_pay[1:0];
      end
      default: w_last = 1'b1;
    endcase
  end

  // A pending restart cuts a non-restart sequence short after the current write.
  assign w_seq_end     = w_last | ((r_cls != EVT_RESTART) & w_pend[0]);
  assign w_after_state = w_seq_end ? ST_IDLE : ST_LOAD;
  assign w_after_step  = w_seq_end ? r_step : r_step + 2'd1;

`ifdef I2C_SCHED_GAP_EN
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_gap_done;
  assign w_gap_done = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // Idle-gap counter, restarted on every m_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end else begin
      r_gap_cnt <= '0;
    end
  end
`endif

  // Next-state logic of the sequencing FSM.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cls   = r_cls;
    w_nxt_step  = r_step;
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_nxt_state = ST_LOAD;
          w_nxt_cls   = w_grant;
          w_nxt_step  = 2'd0;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_LOAD:  w_nxt_state = ST_ISSUE;
      ST_ISSUE: w_nxt_state = m_ready ? ST_WAIT : ST_ISSUE;
      ST_WAIT: begin
        if (m_done) begin
`ifdef I2C_SCHED_GAP_EN
          w_nxt_state = ST_GAP;
`else
          w_nxt_state = w_after_state;
          w_nxt_step  = w_after_step;
`endif
        end else begin
          w_nxt_state = ST_WAIT;
        end
      end
      ST_GAP: begin
`ifdef I2C_SCHED_GAP_EN
        if (w_gap_done) begin
          w_nxt_state = w_after_state;
          w_nxt_step  = w_after_step;
        end else begin
          w_nxt_state = ST_GAP;
        end
`else
        w_nxt_state = ST_IDLE;
`endif
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // FSM state, grant snapshot, bus-facing address/data and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cls     <= EVT_RESTART;
      r_step    <= 2'd0;
      r_snap    <= 4'h0;
      r_slave   <= 7'h00;
      r_reg     <= 8'h00;
      r_data    <= 32'h0000_0000;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cls     <= w_nxt_cls;
      r_step    <= w_nxt_step;
      r_overrun <= r_overrun | (|w_ovr);
      if (r_state == ST_LOAD) begin
        r_snap  <= w_cur_pay;
        r_slave <= w_slave;
        r_reg   <= w_reg;
        r_data  <= {6'b000000, w_val, 24'h000000};
      end else begin
        r_snap  <= r_snap;
        r_slave <= r_slave;
        r_reg   <= r_reg;
        r_data  <= r_data;
      end
    end
  end

  // Start is gated by the live m_ready so it can never fire into a busy master.
  assign m_start      = (r_state == ST_ISSUE) & m_ready;
  assign m_mode       = MODE_REG_WRITE;
  assign m_burst_len  = BURST_1BYTE;
  assign m_slave_addr = r_slave;
  assign m_reg_addr   = r_reg;
  assign m_tx_data    = r_data;
  assign busy         = (r_state != ST_IDLE) | (|w_pend);
  assign overrun      = r_overrun;

endmodule
